// File: rtl/noc_pkg.sv
// Shared NoC flit helpers: field widths/offsets, bus size and destination-XY extraction.
// Flit layout, MSB first: {src_x, src_y, src_local[2:0], dst_x, dst_y, dst_local[2:0], data}.
package noc_pkg;

    localparam int LOCAL_W = 3;
    localparam int MAX_BUS = 512;

    function automatic int hdr_width(input int sx, input int sy);
        return 2 * sx + 2 * sy + 2 * LOCAL_W;
    endfunction

    function automatic int bus_size(input int dw, input int sx, input int sy);
        return dw + hdr_width(sx, sy);
    endfunction

    // LSB of the {dst_x, dst_y} pair, just above dst_local.
    function automatic int dst_lsb(input int dw);
        return dw + LOCAL_W;
    endfunction

    function automatic int src_lsb(input int dw, input int sx, input int sy);
        return dw + LOCAL_W + sx + sy + LOCAL_W;
    endfunction

    function automatic logic [31:0] node_xy(input int x, input int y, input int sy);
        return 32'((x << sy) | y);
    endfunction

    function automatic logic [31:0] dst_xy(input logic [MAX_BUS-1:0] flit, input int dw,
                                           input int sx, input int sy);
        logic [31:0] xy;
        xy = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < sx + sy) xy[i] = flit[dst_lsb(dw) + i];
        end
        return xy;
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Show-ahead synchronous FIFO: head is valid on rd_data whenever empty is low.
module noc_flit_fifo #(
    parameter int WIDTH      = 66,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = DEPTH;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic                  do_wr, do_rd;

    // Full/empty come from the registered count only, so a pop never frees a slot for a same-edge write.
    assign full  = (count_reg == CNT_FULL);
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_reg] <= wr_data;
    end

endmodule

// File: rtl/noc_local_port.sv
// Manager <-> router local-port adapter with TX/RX FIFOs, local loopback and misroute drop.
// Define NOC_LOCAL_PORT_STATS_EN to add saturating tx/rx/drop counters and their stat ports.
module noc_local_port
    import noc_pkg::*;
#(
    parameter int NOC_X          = 0,
    parameter int NOC_Y          = 0,
    parameter int SOC_SIZE_X     = 1,
    parameter int SOC_SIZE_Y     = 1,
    parameter int NOC_DATA_WIDTH = 56,
    parameter int TX_DEPTH_LOG2  = 2,
    parameter int RX_DEPTH_LOG2  = 2,
    localparam int NOC_BUS_SIZE  = bus_size(NOC_DATA_WIDTH, SOC_SIZE_X, SOC_SIZE_Y)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [NOC_BUS_SIZE-1:0] noc_din_i,
    input  logic                    noc_wr_i,
    output logic                    noc_wait_o,
    output logic [NOC_BUS_SIZE-1:0] noc_dout_o,
    output logic                    noc_nd_o,
    input  logic                    noc_rd_i,
    output logic [NOC_BUS_SIZE-1:0] rtr_tx_data_o,
    output logic                    rtr_tx_wr_o,
    input  logic                    rtr_tx_wait_i,
    input  logic [NOC_BUS_SIZE-1:0] rtr_rx_data_i,
    input  logic                    rtr_rx_wr_i,
    output logic                    rtr_rx_wait_o
`ifdef NOC_LOCAL_PORT_STATS_EN
    ,
    output logic [15:0]             stat_tx_cnt_o,
    output logic [15:0]             stat_rx_cnt_o,
    output logic [15:0]             stat_drop_cnt_o
`endif
);

    localparam logic [31:0] LOCAL_XY = node_xy(NOC_X, NOC_Y, SOC_SIZE_Y);

    logic [NOC_BUS_SIZE-1:0] tx_head, rx_head, rx_wdata;
    logic [TX_DEPTH_LOG2:0]  tx_count;
    logic [RX_DEPTH_LOG2:0]  rx_count;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_head_local, rx_in_local, tx_send, loop_go, tx_pop, rtr_accept, rx_wr;
    logic unused_counts;

    assign unused_counts = ^{tx_count, rx_count};

    assign tx_head_local = (dst_xy(MAX_BUS'(tx_head), NOC_DATA_WIDTH, SOC_SIZE_X, SOC_SIZE_Y) == LOCAL_XY);
    assign rx_in_local   = (dst_xy(MAX_BUS'(rtr_rx_data_i), NOC_DATA_WIDTH, SOC_SIZE_X, SOC_SIZE_Y) == LOCAL_XY);

    assign rtr_tx_wr_o   = !tx_empty && !tx_head_local;
    assign rtr_tx_data_o = rtr_tx_wr_o ? tx_head : '0;
    assign tx_send       = rtr_tx_wr_o && !rtr_tx_wait_i;

    // Router writes win the RX port; a local head waits for a cycle with no router strobe.
    assign loop_go    = !tx_empty && tx_head_local && !rx_full && !rtr_rx_wr_i;
    assign tx_pop     = tx_send || loop_go;
    assign rtr_accept = rtr_rx_wr_i && !rx_full;
    assign rx_wr      = (rtr_accept && rx_in_local) || loop_go;
    assign rx_wdata   = rtr_rx_wr_i ? rtr_rx_data_i : tx_head;

    assign noc_wait_o    = tx_full;
    assign rtr_rx_wait_o = rx_full;
    assign noc_nd_o      = !rx_empty;
    assign noc_dout_o    = rx_empty ? '0 : rx_head;

    noc_flit_fifo #(.WIDTH(NOC_BUS_SIZE), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .wr_en   (noc_wr_i),
        .wr_data (noc_din_i),
        .rd_en   (tx_pop),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_count)
    );

    noc_flit_fifo #(.WIDTH(NOC_BUS_SIZE), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .wr_en   (rx_wr),
        .wr_data (rx_wdata),
        .rd_en   (noc_rd_i),
        .rd_data (rx_head),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_count)
    );

`ifdef NOC_LOCAL_PORT_STATS_EN
    logic [2:0] stat_inc;
    assign stat_inc = {rtr_accept && !rx_in_local, rx_wr, tx_send};

    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
        logic [15:0] cnt_reg;
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i)                             cnt_reg <= '0;
            else if (stat_inc[gi] && cnt_reg != 16'hFFFF) cnt_reg <= cnt_reg + 16'd1;
        end
    end

    assign stat_tx_cnt_o   = g_stat[0].cnt_reg;
    assign stat_rx_cnt_o   = g_stat[1].cnt_reg;
    assign stat_drop_cnt_o = g_stat[2].cnt_reg;
`else
    // Without counters a misrouted flit is simply accepted and never written to RX.
`endif

endmodule

// File: tb/tb_noc_local_port.sv
// Scoreboard bench for noc_local_port: directed scenarios plus randomized traffic.
// Manager flits carry src_local=1, router flits src_local=2, so RX pops are matched per stream.
module tb_noc_local_port;

    localparam int BW = 66;
    localparam int DW = 56;
    typedef logic [BW-1:0] flit_t;

    logic        clk, rst_n_i;
    flit_t       noc_din_i, noc_dout_o, rtr_tx_data_o, rtr_rx_data_i;
    logic        noc_wr_i, noc_wait_o, noc_nd_o, noc_rd_i;
    logic        rtr_tx_wr_o, rtr_tx_wait_i, rtr_rx_wr_i, rtr_rx_wait_o;
`ifdef NOC_LOCAL_PORT_STATS_EN
    logic [15:0] stat_tx_cnt_o, stat_rx_cnt_o, stat_drop_cnt_o;
`endif

    noc_local_port #(
        .NOC_X(0), .NOC_Y(0), .SOC_SIZE_X(1), .SOC_SIZE_Y(1),
        .NOC_DATA_WIDTH(DW), .TX_DEPTH_LOG2(2), .RX_DEPTH_LOG2(2)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n_i),
        .noc_din_i     (noc_din_i),
        .noc_wr_i      (noc_wr_i),
        .noc_wait_o    (noc_wait_o),
        .noc_dout_o    (noc_dout_o),
        .noc_nd_o      (noc_nd_o),
        .noc_rd_i      (noc_rd_i),
        .rtr_tx_data_o (rtr_tx_data_o),
        .rtr_tx_wr_o   (rtr_tx_wr_o),
        .rtr_tx_wait_i (rtr_tx_wait_i),
        .rtr_rx_data_i (rtr_rx_data_i),
        .rtr_rx_wr_i   (rtr_rx_wr_i),
        .rtr_rx_wait_o (rtr_rx_wait_o)
`ifdef NOC_LOCAL_PORT_STATS_EN
        ,
        .stat_tx_cnt_o   (stat_tx_cnt_o),
        .stat_rx_cnt_o   (stat_rx_cnt_o),
        .stat_drop_cnt_o (stat_drop_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    flit_t tx_q[$];   // remote manager flits, in order, expected at the router
    flit_t lp_q[$];   // local manager flits, expected at the manager RX
    flit_t rr_q[$];   // local router flits, expected at the manager RX

    function automatic flit_t mk(input int sx, input int sy, input int sl,
                                 input int dx, input int dy, input int dl, input logic [DW-1:0] d);
        return {sx[0], sy[0], sl[2:0], dx[0], dy[0], dl[2:0], d};
    endfunction

    function automatic bit is_local(input flit_t f);
        return (f[DW+4] == 1'b0) && (f[DW+3] == 1'b0);
    endfunction

    task automatic checkf(input string name, input flit_t act, input flit_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input flit_t act);
        total++;
        bad++;
        $display("FAIL %s: got %h want no flit", name, act);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: every accepted transfer is classified by its destination.
    always @(negedge clk) begin
        if (rst_n_i) begin
            if (noc_wr_i && !noc_wait_o) begin
                if (is_local(noc_din_i)) lp_q.push_back(noc_din_i);
                else                     tx_q.push_back(noc_din_i);
            end
            if (rtr_rx_wr_i && !rtr_rx_wait_o && is_local(rtr_rx_data_i))
                rr_q.push_back(rtr_rx_data_i);
        end
    end

    // Monitor: compares every flit leaving the DUT against the front of its stream.
    always @(negedge clk) begin
        if (rst_n_i) begin
            if (rtr_tx_wr_o && !rtr_tx_wait_i) begin
                $display("router tx  %h", rtr_tx_data_o);
                if (tx_q.size() == 0) unexpected("tx_extra", rtr_tx_data_o);
                else                  checkf("tx_data", rtr_tx_data_o, tx_q.pop_front());
            end
            if (noc_rd_i && noc_nd_o) begin
                $display("manager rx %h", noc_dout_o);
                if (noc_dout_o[63:61] == 3'd1) begin
                    if (lp_q.size() == 0) unexpected("rx_loop_extra", noc_dout_o);
                    else                  checkf("rx_loop", noc_dout_o, lp_q.pop_front());
                end else if (noc_dout_o[63:61] == 3'd2) begin
                    if (rr_q.size() == 0) unexpected("rx_rtr_extra", noc_dout_o);
                    else                  checkf("rx_rtr", noc_dout_o, rr_q.pop_front());
                end else begin
                    unexpected("rx_bad_src", noc_dout_o);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        flit_t loop_f, rtr_f;
        rst_n_i = 1'b0;
        noc_din_i = '0; noc_wr_i = 1'b0; noc_rd_i = 1'b0;
        rtr_tx_wait_i = 1'b0; rtr_rx_data_i = '0; rtr_rx_wr_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1: reset release
        rst_n_i = 1'b1;
        check1("rst_noc_wait", noc_wait_o, 1'b0);
        check1("rst_rx_wait", rtr_rx_wait_o, 1'b0);
        check1("rst_nd", noc_nd_o, 1'b0);
        check1("rst_tx_wr", rtr_tx_wr_o, 1'b0);
        checkf("rst_dout", noc_dout_o, '0);
        checkf("rst_tx_data", rtr_tx_data_o, '0);
        step();
        check1("rel_noc_wait", noc_wait_o, 1'b0);
        check1("rel_rx_wait", rtr_rx_wait_o, 1'b0);
        check1("rel_nd", noc_nd_o, 1'b0);

        // 2: TX fill while router stalls, then drain in order
        rtr_tx_wait_i = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            noc_wr_i  = 1'b1;
            noc_din_i = mk(0, 0, 1, 1, 0, 0, DW'(i));
            step();
            check1("tx_wait_fill", noc_wait_o, i >= 4);
        end
        noc_wr_i = 1'b0;
        checki("tx_accepted", tx_q.size(), 4);
        rtr_tx_wait_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check1("tx_one_per_cycle", rtr_tx_wr_o, 1'b1);
            step();
        end
        check1("tx_drained", rtr_tx_wr_o, 1'b0);
        checki("tx_q_empty", tx_q.size(), 0);
`ifdef NOC_LOCAL_PORT_STATS_EN
        checki("stat_tx", int'(stat_tx_cnt_o), 4);
`endif

        // 3: router flit to this node, then manager pop
        rtr_rx_wr_i   = 1'b1;
        rtr_rx_data_i = mk(1, 1, 2, 0, 0, 0, 56'hABCD);
        step();
        rtr_rx_wr_i = 1'b0;
        check1("rx_nd", noc_nd_o, 1'b1);
        checkf("rx_head", noc_dout_o, mk(1, 1, 2, 0, 0, 0, 56'hABCD));
        noc_rd_i = 1'b1;
        step();
        noc_rd_i = 1'b0;
        check1("rx_nd_after_pop", noc_nd_o, 1'b0);

        // 4: loopback loses the RX port to a same-cycle router write
        loop_f = mk(0, 0, 1, 0, 0, 0, 56'h11);
        rtr_f  = mk(1, 1, 2, 0, 0, 0, 56'h22);
        noc_wr_i = 1'b1; noc_din_i = loop_f;
        step();
        noc_wr_i = 1'b0;
        rtr_rx_wr_i = 1'b1; rtr_rx_data_i = rtr_f;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check1("loop_no_tx_wr", rtr_tx_wr_o, 1'b0);
            step();
            rtr_rx_wr_i = 1'b0;
        end
        checkf("loop_order_first", noc_dout_o, rtr_f);
        noc_rd_i = 1'b1;
        step();
        noc_rd_i = 1'b0;
        checkf("loop_order_second", noc_dout_o, loop_f);
        noc_rd_i = 1'b1;
        step();
        noc_rd_i = 1'b0;
        check1("loop_nd_clear", noc_nd_o, 1'b0);

        // 5: misrouted router flit is accepted and dropped
        rtr_rx_wr_i = 1'b1; rtr_rx_data_i = mk(1, 1, 2, 1, 1, 0, 56'h55);
        @(negedge clk);
        check1("misroute_accept", rtr_rx_wait_o, 1'b0);
        step();
        rtr_rx_wr_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check1("misroute_nd", noc_nd_o, 1'b0);
            step();
        end
`ifdef NOC_LOCAL_PORT_STATS_EN
        checki("stat_drop", int'(stat_drop_cnt_o), 1);
        checki("stat_rx", int'(stat_rx_cnt_o), 3);
`endif

        // Randomized mixed traffic
        for (int c = 0; c < 400; c++) begin
            int r, xy;
            logic [DW-1:0] d;
            noc_wr_i = 1'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 9));
            xy = (r < 3) ? 0 : int'($urandom_range(1, 3));
            d  = DW'({$urandom(), $urandom()});
            noc_din_i = mk(0, 0, 1, xy >> 1, xy & 1, 0, d);
            rtr_rx_wr_i = 1'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 3));
            xy = (r < 3) ? 0 : int'($urandom_range(1, 3));
            d  = DW'({$urandom(), $urandom()});
            rtr_rx_data_i = mk(1, 1, 2, xy >> 1, xy & 1, 0, d);
            rtr_tx_wait_i = ($urandom_range(0, 9) < 3);
            noc_rd_i      = 1'($urandom_range(0, 1));
            step();
        end
        noc_wr_i = 1'b0; rtr_rx_wr_i = 1'b0; rtr_tx_wait_i = 1'b0; noc_rd_i = 1'b1;
        repeat (20) step();
        noc_rd_i = 1'b0;
        checki("rand_tx_left", tx_q.size(), 0);
        checki("rand_loop_left", lp_q.size(), 0);
        checki("rand_rtr_left", rr_q.size(), 0);
        check1("rand_nd_idle", noc_nd_o, 1'b0);

        // 6: reset mid-stream flushes both FIFOs
        rtr_tx_wait_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            noc_wr_i = 1'b1;    noc_din_i     = mk(0, 0, 1, 1, 1, 0, DW'(16 + i));
            rtr_rx_wr_i = 1'b1; rtr_rx_data_i = mk(1, 1, 2, 0, 0, 0, DW'(32 + i));
            step();
        end
        noc_wr_i = 1'b0; rtr_rx_wr_i = 1'b0;
        check1("pre_rst_nd", noc_nd_o, 1'b1);
        check1("pre_rst_tx_wr", rtr_tx_wr_o, 1'b1);
        @(negedge clk);
        #2;
        rst_n_i = 1'b0;
        #1;
        check1("mid_rst_nd", noc_nd_o, 1'b0);
        check1("mid_rst_tx_wr", rtr_tx_wr_o, 1'b0);
        check1("mid_rst_noc_wait", noc_wait_o, 1'b0);
        check1("mid_rst_rx_wait", rtr_rx_wait_o, 1'b0);
        checkf("mid_rst_dout", noc_dout_o, '0);
        checkf("mid_rst_tx_data", rtr_tx_data_o, '0);
        tx_q.delete(); lp_q.delete(); rr_q.delete();
        step();
        rst_n_i = 1'b1; rtr_tx_wait_i = 1'b0; noc_rd_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check1("post_rst_nd", noc_nd_o, 1'b0);
            check1("post_rst_tx_wr", rtr_tx_wr_o, 1'b0);
            step();
        end
        noc_rd_i = 1'b0;
`ifdef NOC_LOCAL_PORT_STATS_EN
        checki("stat_drop_rst", int'(stat_drop_cnt_o), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
